// File: rtl/cam_tag_pkg.sv
// Shared sizing and the FIFO entry type for the CAM tag result path.
// Optional feature macro used by cam_tag_collector: TAG_HIST_EN.
package cam_tag_pkg;

    localparam int TAG_W = 16;
    localparam int IDX_W = $clog2(TAG_W);
    localparam int CNT_W = 8;
    localparam int DEPTH = 4;

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic             last;
    } tag_entry_t;

endpackage

// File: rtl/cam_tag_fifo.sv
// Synchronous FIFO with occupancy counter; caller must not push when full
// without a same-cycle pop, nor pop when empty.
module cam_tag_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 17
) (
    input  logic                       CLK,
    input  logic                       rst,
    input  logic                       clr_i,
    input  logic                       push_i,
    input  logic [W-1:0]               din_i,
    input  logic                       pop_i,
    output logic [W-1:0]               dout_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = $clog2(DEPTH+1);

    logic [W-1:0]     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0] cnt_q, cnt_d;

    // DEPTH is a power of two, so pointers wrap by natural overflow.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push_i) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop_i)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({push_i, pop_i})
            2'b10:   cnt_d = cnt_q + OCC_W'(1);
            2'b01:   cnt_d = cnt_q - OCC_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge CLK or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else if (clr_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (push_i) mem_q[wr_ptr_q] <= din_i;
    end

    assign dout_o  = mem_q[rd_ptr_q];
    assign full_o  = (cnt_q == OCC_W'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign count_o = cnt_q;

endmodule

// File: rtl/cam_tag_collector.sv
// Buffers CAM tag words and emits decoded results (hit, lowest index, popcount).
// Define TAG_HIST_EN to add saturating per-row hit counters readable via hist_sel.
module cam_tag_collector
    import cam_tag_pkg::*;
(
    input  logic             CLK,
    input  logic             rst,
    input  logic             clr,
    input  logic [TAG_W-1:0] tag_in,
    input  logic             tag_valid,
    input  logic             tag_last,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [TAG_W-1:0] res_tag,
    output logic             res_hit,
    output logic [IDX_W-1:0] res_idx,
    output logic [IDX_W:0]   res_cnt,
    output logic             res_last,
    output logic             ovf,
    input  logic [IDX_W-1:0] hist_sel,
    output logic [CNT_W-1:0] hist_cnt
);

    function automatic logic [IDX_W-1:0] low_idx(input logic [TAG_W-1:0] t);
        logic [IDX_W-1:0] r;
        r = '0;
        for (int i = TAG_W-1; i >= 0; i--) if (t[i]) r = IDX_W'(i);
        return r;
    endfunction

    function automatic logic [IDX_W:0] pop_cnt(input logic [TAG_W-1:0] t);
        logic [IDX_W:0] c;
        c = '0;
        for (int i = 0; i < TAG_W; i++) c = c + {{IDX_W{1'b0}}, t[i]};
        return c;
    endfunction

    tag_entry_t                  wr_entry, rd_entry;
    logic                        fifo_full, fifo_empty;
    logic [$clog2(DEPTH+1)-1:0]  fifo_count_unused;
    logic                        push, pop, drop;

    logic             res_valid_q;
    logic [TAG_W-1:0] res_tag_q;
    logic             res_hit_q, res_last_q, ovf_q;
    logic [IDX_W-1:0] res_idx_q;
    logic [IDX_W:0]   res_cnt_q;

    // Stream contract: a result transfers on a cycle with res_valid && res_ready;
    // while res_valid is high and res_ready low every res_* output holds steady,
    // and res_valid never depends combinationally on res_ready.
    assign pop  = !clr && !fifo_empty && (!res_valid_q || res_ready);
    assign push = !clr && tag_valid && (!fifo_full || pop);
    assign drop = !clr && tag_valid && fifo_full && !pop;

    assign wr_entry.tag  = tag_in;
    assign wr_entry.last = tag_last;

    cam_tag_fifo #(.DEPTH(DEPTH), .W($bits(tag_entry_t))) u_fifo (
        .CLK     (CLK),
        .rst     (rst),
        .clr_i   (clr),
        .push_i  (push),
        .din_i   (wr_entry),
        .pop_i   (pop),
        .dout_o  (rd_entry),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count_unused)
    );

    always_ff @(posedge CLK or negedge rst) begin
        if (!rst) begin
            res_valid_q <= 1'b0;
            res_tag_q   <= '0;
            res_hit_q   <= 1'b0;
            res_idx_q   <= '0;
            res_cnt_q   <= '0;
            res_last_q  <= 1'b0;
            ovf_q       <= 1'b0;
        end else if (clr) begin
            res_valid_q <= 1'b0;
            res_tag_q   <= '0;
            res_hit_q   <= 1'b0;
            res_idx_q   <= '0;
            res_cnt_q   <= '0;
            res_last_q  <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            if (pop) begin
                res_valid_q <= 1'b1;
                res_tag_q   <= rd_entry.tag;
                res_hit_q   <= |rd_entry.tag;
                res_idx_q   <= low_idx(rd_entry.tag);
                res_cnt_q   <= pop_cnt(rd_entry.tag);
                res_last_q  <= rd_entry.last;
            end else if (res_ready) begin
                res_valid_q <= 1'b0;
            end
            if (drop) ovf_q <= 1'b1;
        end
    end

    assign res_valid = res_valid_q;
    assign res_tag   = res_tag_q;
    assign res_hit   = res_hit_q;
    assign res_idx   = res_idx_q;
    assign res_cnt   = res_cnt_q;
    assign res_last  = res_last_q;
    assign ovf       = ovf_q;

`ifdef TAG_HIST_EN
    logic [CNT_W-1:0] hist_q [TAG_W];
    logic [CNT_W-1:0] hist_cnt_q;

    // Counters saturate so long sweeps never wrap back to small values.
    always_ff @(posedge CLK or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < TAG_W; i++) hist_q[i] <= '0;
            hist_cnt_q <= '0;
        end else if (clr) begin
            for (int i = 0; i < TAG_W; i++) hist_q[i] <= '0;
            hist_cnt_q <= '0;
        end else begin
            if (pop) begin
                for (int i = 0; i < TAG_W; i++)
                    if (rd_entry.tag[i] && (hist_q[i] != '1)) hist_q[i] <= hist_q[i] + CNT_W'(1);
            end
            hist_cnt_q <= hist_q[hist_sel];
        end
    end

    assign hist_cnt = hist_cnt_q;
`else
    logic hist_sel_unused;
    assign hist_sel_unused = ^hist_sel;
    assign hist_cnt        = '0;
`endif

endmodule
